// File: rtl/ofifo_psum_collector.sv
`default_nettype none
// ============================================================================
//  Module      : ofifo_psum_collector
//  Description : Per-column psum FIFO lanes with a shared read pointer; a row
//                becomes visible only when every lane holds data.
//  Revision    : 1.0 - initial release
// ============================================================================
module ofifo_psum_collector #(
    parameter int PSUM_BW = 16,
    parameter int COL     = 8,
    parameter int DEPTH   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PSUM_BW*COL-1:0] in,
    input  logic [COL-1:0]         wr,
    input  logic                   rd,
    output logic [PSUM_BW*COL-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    localparam int             c_aw    = $clog2(DEPTH);
    localparam int             c_pw    = c_aw + 1;
    localparam logic [c_pw-1:0] c_depth = c_pw'(DEPTH);

    logic [c_pw-1:0] r_rp;
    logic [COL-1:0]  w_nempty;
    logic [COL-1:0]  w_full;
    logic            w_valid;
    logic            w_pop;

    assign w_valid = &w_nempty;
    assign w_pop   = rd & w_valid;

    genvar c;
    generate
        for (c = 0; c < COL; c++) begin : g_lane
            logic [PSUM_BW-1:0] r_mem [DEPTH];
            logic [c_pw-1:0]    r_wp;
            logic [c_pw-1:0]    w_cnt;
            logic               w_push;

            // Extra pointer MSB distinguishes a full lane from an empty one.
            assign w_cnt       = r_wp - r_rp;
            assign w_nempty[c] = (w_cnt != '0);
            assign w_full[c]   = (w_cnt == c_depth);
            assign w_push      = wr[c] & ~w_full[c];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wp <= '0;
                end else if (w_push) begin
                    r_wp <= r_wp + c_pw'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset && w_push) begin
                    r_mem[r_wp[c_aw-1:0]] <= in[PSUM_BW*c +: PSUM_BW];
                end
            end

            assign out[PSUM_BW*c +: PSUM_BW] = w_valid ? r_mem[r_rp[c_aw-1:0]] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rp <= '0;
        end else if (w_pop) begin
            r_rp <= r_rp + c_pw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow <= 1'b0;
        end else if (|(wr & w_full)) begin
            o_overflow <= 1'b1;
        end
    end

    assign o_valid = w_valid;
    assign o_full  = |w_full;
    assign o_ready = ~o_full;

endmodule
`default_nettype wire

// File: tb/tb_ofifo_psum_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofifo_psum_collector
//  Description : Directed self-checking bench for ofifo_psum_collector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofifo_psum_collector;

    localparam int c_bw  = 16;
    localparam int c_col = 8;
    localparam int c_dep = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [c_bw*c_col-1:0]  in_bus;
    logic [c_col-1:0]       wr;
    logic                   rd;
    logic [c_bw*c_col-1:0]  out_bus;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    ofifo_psum_collector #(
        .PSUM_BW(c_bw),
        .COL    (c_col),
        .DEPTH  (c_dep)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_bus),
        .wr        (wr),
        .rd        (rd),
        .out       (out_bus),
        .o_valid   (o_valid),
        .o_full    (o_full),
        .o_ready   (o_ready),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Row whose lane c holds base + c.
    function automatic logic [127:0] mk_row(input int base);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < c_col; c++) r[c_bw*c +: c_bw] = 16'(base + c);
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [127:0] exp_row;
        int           popped;
        int           r;

        reset  = 1'b0;
        in_bus = '0;
        wr     = '0;
        rd     = 1'b0;
        #2;

        // 1: reset state
        do_reset();
        check("rst_valid", o_valid, 0);
        check("rst_full", o_full, 0);
        check("rst_ready", o_ready, 1);
        check("rst_ovf", o_overflow, 0);
        check("rst_out", out_bus, 0);

        // 2: skewed single row
        for (int c = 0; c < c_col; c++) begin
            check("skew_valid_low", o_valid, 0);
            in_bus = mk_row(16'h0100);
            wr     = 8'(1 << c);
            step();
        end
        wr = '0;
        check("skew_valid", o_valid, 1);
        check("skew_row", out_bus, mk_row(16'h0100));
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("skew_popped", o_valid, 0);

        // 3: fill lane 0, then overflow
        for (int i = 0; i < c_dep; i++) begin
            in_bus = '0;
            in_bus[c_bw-1:0] = 16'(16'h1000 + i);
            wr = 8'h01;
            step();
        end
        wr = '0;
        check("fill_full", o_full, 1);
        check("fill_ready", o_ready, 0);
        check("fill_valid", o_valid, 0);
        check("fill_ovf0", o_overflow, 0);
        in_bus[c_bw-1:0] = 16'hDEAD;
        wr = 8'h01;
        step();
        wr = '0;
        check("ovf_set", o_overflow, 1);
        check("ovf_full", o_full, 1);
        in_bus = mk_row(16'h2000);
        wr     = 8'hFE;
        step();
        wr = '0;
        exp_row = mk_row(16'h2000);
        exp_row[c_bw-1:0] = 16'h1000;
        check("ovf_valid", o_valid, 1);
        check("ovf_head", out_bus, exp_row);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("ovf_popped", o_valid, 0);
        check("ovf_notfull", o_full, 0);
        check("ovf_sticky", o_overflow, 1);

        // 4: rd ignored while a lane is empty
        do_reset();
        check("rst2_ovf", o_overflow, 0);
        in_bus = mk_row(16'h3000);
        wr     = 8'h7F;
        step();
        wr = '0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("norpop_valid", o_valid, 0);
        wr = 8'h80;
        step();
        wr = '0;
        check("norpop_valid1", o_valid, 1);
        check("norpop_row", out_bus, mk_row(16'h3000));
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("norpop_drain", o_valid, 0);

        // 5: stream 100 skewed rows with rd = o_valid
        popped = 0;
        for (int t = 0; t < 130; t++) begin
            wr     = '0;
            in_bus = '0;
            for (int c = 0; c < c_col; c++) begin
                r = t - c;
                if (r >= 0 && r < 100) begin
                    wr[c] = 1'b1;
                    in_bus[c_bw*c +: c_bw] = 16'(r * 8 + c);
                end
            end
            rd = o_valid;
            if (o_valid) begin
                check("stream_row", out_bus, mk_row(popped * 8));
                popped++;
            end
            step();
        end
        wr = '0;
        rd = 1'b0;
        check("stream_count", 128'(popped), 128'(100));
        check("stream_ovf", o_overflow, 0);
        check("stream_empty", o_valid, 0);

        // 6: reset mid-write
        for (int i = 0; i < 10; i++) begin
            in_bus = mk_row(16'h4000 + i * 8);
            wr     = 8'hFF;
            if (i == 6) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        wr = '0;
        reset = 1'b1;
        wr = 8'hFF;
        step();
        reset = 1'b0;
        wr = '0;
        check("mid_valid", o_valid, 0);
        check("mid_full", o_full, 0);
        check("mid_ovf", o_overflow, 0);
        check("mid_out", out_bus, 0);
        in_bus = mk_row(16'h5000);
        wr     = 8'hFF;
        step();
        wr = '0;
        check("fresh_valid", o_valid, 1);
        check("fresh_row", out_bus, mk_row(16'h5000));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
